bs_to_bin: RTL
==============

BS_TO_BIN -- requirements
Module: bs_to_bin

Interface
REQ-001 SHALL have parameter WINLOG, default 16, log2 of window length (window = 2^WINLOG bitstream cycles; 16 matches two chained 8-bit Sobol periods).
REQ-002 SHALL have parameter OUTWD, default WINLOG+1, width of oData (holds full count 0..2^WINLOG).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin one conversion window.
REQ-006 iBit  input  1  unipolar stochastic bitstream (e.g. product stream from upstream multiplier).
REQ-007 iReady  input  1  downstream accepts oData when high with oValid.
REQ-008 oBusy  output  1  high while accumulating (state ACC).
REQ-009 oValid  output  1  oData holds a completed result.
REQ-010 oData  output  OUTWD  count of ones in the window.
REQ-011 oOvf  output  1  sticky: a result was overwritten before being accepted.

Function
REQ-012 SHALL implement FSM states IDLE, ACC, HOLD; reset state IDLE.
REQ-013 IDLE: start=1 -> ACC next cycle; accumulator and window counter cleared; iBit in start cycle not sampled.
REQ-014 ACC: each cycle accumulator += iBit, window counter += 1; samples taken in exactly the 2^WINLOG cycles following the start cycle.
REQ-015 On the last sample (window counter all ones), final count (including that sample) SHALL be registered into oData and oValid asserted the next cycle; state -> HOLD.
REQ-016 Latency: oValid high exactly 2^WINLOG+1 cycles after start sampled high.
REQ-017 HOLD: oData and oValid stable until oValid&iReady; then oValid=0 and state -> IDLE next cycle.
REQ-018 start while in ACC or HOLD SHALL be ignored (no restart, no error).
REQ-019 Accumulator SHALL be OUTWD bits; all-ones input yields exactly 2^WINLOG, no wrap; window counter WINLOG bits, wraps to 0 at window end.
REQ-020 oBusy=1 only in ACC; oValid=1 only when a result is pending.
REQ-021 oOvf SHALL clear only on reset; without BS2B_CONT_EN it stays 0.

Reset
REQ-022 rst asserted at any time (including mid-ACC or HOLD) SHALL immediately force IDLE, oData=0, oValid=0, oBusy=0, oOvf=0, accumulator=0, window counter=0; partial result discarded.
REQ-023 After rst deasserts, no conversion starts until a new start pulse.

Configuration
REQ-024 Macro BS2B_CONT_EN: when defined, continuous mode -- after the first start, windows run back-to-back with no gap; ACC never leaves to IDLE; each window end loads oData/asserts oValid while the accumulator restarts in the same cycle with the next sample.
REQ-025 With BS2B_CONT_EN, if a window ends while oValid=1 and not accepted that cycle, oData is overwritten with the new result, oValid stays 1, oOvf set; simultaneous accept and window end is not overflow.
REQ-026 Without BS2B_CONT_EN, behaviour is REQ-012..REQ-021 exactly (single-shot).

Structure
REQ-027 Shared package bs_pkg SHALL hold the state enum typedef (IDLE/ACC/HOLD) and default constants for WINLOG and OUTWD.
REQ-028 Window counter SHALL be sub-module bs_win_cnt (WINLOG-bit counter with clear, enable, terminal-count output).

Verification (WINLOG=4, OUTWD=5, window 16)
REQ-029 start, iBit=1 for 16 cycles -> oValid at cycle 17 after start, oData=16, oOvf=0.
REQ-030 start, iBit alternating 1,0 (first sample 1) -> oData=8; iBit=0 throughout -> oData=0.
REQ-031 iReady=0 for 5 cycles after oValid -> oData/oValid stable; iReady=1 -> oValid low next cycle, state IDLE; start during HOLD ignored.
REQ-032 rst pulsed at sample 7 of ACC -> all outputs 0 next edge, no oValid without new start; next start with iBit=1 -> oData=16.
REQ-033 BS2B_CONT_EN, iBit=1, iReady=0 -> oValid at cycle 17, second window end at cycle 33 -> oOvf=1, oData=16; iReady=1 at cycle 33 -> oOvf stays 0.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared definitions for the bitstream-to-binary converter.
// Holds the FSM state type and the default window/width constants.
package bs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Default window: 2^16 cycles, which spans two chained 8-bit Sobol periods.
  localparam int WINLOG_DEF = 16;
  // Wide enough to hold a full window of ones (0..2^WINLOG).
  localparam int OUTWD_DEF  = WINLOG_DEF + 1;

endpackage

// File: rtl/bs_win_cnt.sv
// Window counter for bs_to_bin.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear to zero (has priority over en)
//   en        - advance the counter by one
//   cnt       - current count, WINLOG bits, wraps to zero
//   tc        - terminal count: high while cnt is all ones
module bs_win_cnt
  import bs_pkg::*;
#(
  parameter int WINLOG = WINLOG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [WINLOG-1:0] cnt,
  output logic              tc
);

  logic [WINLOG-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign tc  = &cnt_reg;

endmodule

// File: rtl/bs_to_bin.sv
// Stochastic bitstream to binary converter: counts the ones of iBit over a
// window of 2^WINLOG cycles following a start pulse and presents the count
// on oData with a valid/ready handshake.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   start    - one-cycle request to begin a conversion window
//   iBit     - unipolar stochastic bitstream
//   iReady   - downstream accepts oData when high with oValid
//   oBusy    - high while accumulating
//   oValid   - oData holds a completed result
//   oData    - count of ones in the window (OUTWD bits)
//   oOvf     - sticky: a pending result was overwritten before acceptance
// Configuration macro BS2B_CONT_EN: when defined, windows run back-to-back
// after the first start and oOvf reports unaccepted results being replaced.
// When undefined, each start produces exactly one result.
module bs_to_bin
  import bs_pkg::*;
#(
  parameter int WINLOG = WINLOG_DEF,
  parameter int OUTWD  = WINLOG + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             iBit,
  input  logic             iReady,
  output logic             oBusy,
  output logic             oValid,
  output logic [OUTWD-1:0] oData,
  output logic             oOvf
);

  state_t            state_reg;
  logic [OUTWD-1:0]  acc_reg;
  logic [OUTWD-1:0]  data_reg;
  logic              valid_reg;
  logic              ovf_reg;

  logic [WINLOG-1:0] win_cnt;
  logic              win_tc;
  logic [OUTWD-1:0]  bit_ext;
  logic [OUTWD-1:0]  acc_next;

  // Counter is held at zero in IDLE so a window always starts from sample 0.
  bs_win_cnt #(
    .WINLOG(WINLOG)
  ) u_win_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_reg == IDLE),
    .en (state_reg == ACC),
    .cnt(win_cnt),
    .tc (win_tc)
  );

  assign bit_ext  = {{(OUTWD-1){1'b0}}, iBit};
  // Includes the current sample, so on the terminal cycle this is the final count.
  assign acc_next = acc_reg + bit_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The start-cycle bit is deliberately not sampled.
          if (start) begin
            state_reg <= ACC;
            acc_reg   <= '0;
          end
        end
        ACC: begin
          if (win_tc) begin
            acc_reg   <= '0;
            data_reg  <= acc_next;
            valid_reg <= 1'b1;
`ifdef BS2B_CONT_EN
            // Accepted in the same cycle as the new result lands: no loss.
            if (valid_reg && !iReady) begin
              ovf_reg <= 1'b1;
            end
`else
            state_reg <= HOLD;
`endif
          end else begin
            acc_reg <= acc_next;
`ifdef BS2B_CONT_EN
            if (valid_reg && iReady) begin
              valid_reg <= 1'b0;
            end
`endif
          end
        end
        HOLD: begin
          if (valid_reg && iReady) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oBusy  = (state_reg == ACC);
  assign oValid = valid_reg;
  assign oData  = data_reg;
  assign oOvf   = ovf_reg;

endmodule
